// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor: registers, A, G and IR share one bus; Run/Done FSM T0..T3.
// Optional feature macro: PROC_MVNZ_EN (opcode 101 = mvnz Rx,Ry, conditional on G != 0).
module processador_multiciclo_param #(
   parameter int DATA_W    = 16,
   parameter int REG_SEL_W = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] DIN,
   input  logic              Run,
   output logic              Done,
   output logic [DATA_W-1:0] BusWires
);

   localparam int IW    = 3 + 2*REG_SEL_W;
   localparam int NREGS = 2**REG_SEL_W;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
`ifdef PROC_MVNZ_EN
   localparam logic [2:0] OP_MVNZ = 3'b101;
`endif

   if (DATA_W < IW) begin : g_bad_width
      $error("DATA_W must be at least 3 + 2*REG_SEL_W");
   end

   typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

   state_t                 state;
   logic [DATA_W-1:0]      r [NREGS];
   logic [DATA_W-1:0]      a;
   logic [DATA_W-1:0]      g;
   logic [IW-1:0]          ir;

   logic [2:0]             op;
   logic [REG_SEL_W-1:0]   rx;
   logic [REG_SEL_W-1:0]   ry;
   logic [DATA_W-1:0]      bus;
   logic [DATA_W-1:0]      alu_res;
   logic                   wr_rx;
   logic                   a_en;
   logic                   g_en;

   assign op = ir[IW-1 -: 3];
   assign rx = ir[2*REG_SEL_W-1 -: REG_SEL_W];
   assign ry = ir[REG_SEL_W-1:0];

   function automatic logic is_alu(input logic [2:0] o);
      return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND);
   endfunction

   // Bus source and register enables decode from state and IR only; idle bus is zero.
   always_comb begin
      bus   = '0;
      wr_rx = 1'b0;
      a_en  = 1'b0;
      g_en  = 1'b0;
      unique case (state)
         T0: begin
            if (Run) bus = DIN;
         end
         T1: begin
            case (op)
               OP_MV: begin
                  bus   = r[ry];
                  wr_rx = 1'b1;
               end
               OP_MVI: begin
                  bus   = DIN;
                  wr_rx = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  bus  = r[rx];
                  a_en = 1'b1;
               end
`ifdef PROC_MVNZ_EN
               OP_MVNZ: begin
                  bus   = r[ry];
                  wr_rx = (g != '0);
               end
`endif
               default: ;
            endcase
         end
         T2: begin
            bus  = r[ry];
            g_en = 1'b1;
         end
         T3: begin
            bus   = g;
            wr_rx = 1'b1;
         end
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = a + bus;
         OP_SUB:  alu_res = a - bus;
         OP_AND:  alu_res = a & bus;
         default: alu_res = '0;
      endcase
   end

   assign BusWires = bus;

   // Done is registered one step ahead so it is high exactly in the final step.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= T0;
         Done  <= 1'b0;
         ir    <= '0;
         a     <= '0;
         g     <= '0;
         for (int k = 0; k < NREGS; k++) r[k] <= '0;
      end else begin
         if (wr_rx) r[rx] <= bus;
         if (a_en)  a     <= bus;
         if (g_en)  g     <= alu_res;
         unique case (state)
            T0: begin
               Done <= 1'b0;
               if (Run) begin
                  ir    <= DIN[IW-1:0];
                  state <= T1;
                  Done  <= !is_alu(DIN[IW-1 -: 3]);
               end
            end
            T1: begin
               Done  <= 1'b0;
               state <= is_alu(op) ? T2 : T0;
            end
            T2: begin
               Done  <= 1'b1;
               state <= T3;
            end
            T3: begin
               Done  <= 1'b0;
               state <= T0;
            end
         endcase
      end
   end

endmodule
